// File: rtl/seq_comparator_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
// Holds the FSM state encoding and the slice width used by the datapath.
package seq_comparator_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_comparator_pkg

// File: rtl/comp_4.sv
// 4-bit cascadable unsigned magnitude comparator slice.
// Purely combinational, no latency, no flow control.
// Unequal nibbles decide the result; equal nibbles pass the cascade inputs through.
module comp_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       gt_in,
    input  logic       eq_in,
    input  logic       lt_in,
    output logic       gt_out,
    output logic       eq_out,
    output logic       lt_out
);

    logic nib_gt;
    logic nib_eq;
    logic nib_lt;

    assign nib_gt = (a > b);
    assign nib_eq = (a == b);
    assign nib_lt = (a < b);

    assign gt_out = nib_gt | (nib_eq & gt_in);
    assign eq_out = nib_eq & eq_in;
    assign lt_out = nib_lt | (nib_eq & lt_in);

endmodule : comp_4

// File: rtl/seq_comparator.sv
// Unsigned A/B magnitude comparator, one nibble per cycle through a single comp_4 slice.
// Latency: WIDTH/4 cycles from acceptance to the done pulse.
// Backpressure: start is accepted only in IDLE; it is ignored (not queued) while busy.
module seq_comparator
    import seq_comparator_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N     = WIDTH / NIB_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("seq_comparator: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [IDX_W-1:0] idx;
    logic             c_gt;
    logic             c_eq;
    logic             c_lt;
    logic             s_gt;
    logic             s_eq;
    logic             s_lt;
    logic             last_nib;

    // Operands shift right so the slice always sees the current nibble at [3:0].
    comp_4 u_slice (
        .a      (a_sh[NIB_W-1:0]),
        .b      (b_sh[NIB_W-1:0]),
        .gt_in  (c_gt),
        .eq_in  (c_eq),
        .lt_in  (c_lt),
        .gt_out (s_gt),
        .eq_out (s_eq),
        .lt_out (s_lt)
    );

    assign last_nib = (idx == IDX_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_nib) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            idx  <= '0;
            c_gt <= 1'b0;
            c_eq <= 1'b0;
            c_lt <= 1'b0;
            gt   <= 1'b0;
            eq   <= 1'b0;
            lt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        idx  <= '0;
                        // Preset to "equal" so an all-equal operand pair resolves to eq.
                        c_gt <= 1'b0;
                        c_eq <= 1'b1;
                        c_lt <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> NIB_W;
                    b_sh <= b_sh >> NIB_W;
                    c_gt <= s_gt;
                    c_eq <= s_eq;
                    c_lt <= s_lt;
                    if (last_nib) begin
                        gt <= s_gt;
                        eq <= s_eq;
                        lt <= s_lt;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : seq_comparator

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator at WIDTH=8 and WIDTH=32 with hand-computed results.
module tb_seq_comparator;

    logic        clk;
    logic        rst8_n;
    logic        rst32_n;
    logic        start8;
    logic        start32;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        busy8, done8, gt8, eq8, lt8;
    logic        busy32, done32, gt32, eq32, lt32;

    int n_chk  = 0;
    int n_pass = 0;

    seq_comparator #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .gt    (gt8),
        .eq    (eq8),
        .lt    (lt8)
    );

    seq_comparator #(.WIDTH(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst32_n),
        .start (start32),
        .a     (a32),
        .b     (b32),
        .busy  (busy32),
        .done  (done32),
        .gt    (gt32),
        .eq    (eq32),
        .lt    (lt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One full transaction: accept, scramble operands, measure latency, check result and return to IDLE.
    task automatic run_cmp(input bit w32, input logic [31:0] av, input logic [31:0] bv,
                           input int lat, input logic [2:0] gel, input string tag);
        int c;
        @(negedge clk);
        if (w32) begin start32 = 1'b1; a32 = av; b32 = bv; end
        else     begin start8  = 1'b1; a8  = av[7:0]; b8 = bv[7:0]; end
        @(posedge clk); #1;
        start8  = 1'b0;
        start32 = 1'b0;
        if (w32) begin a32 = ~av; b32 = ~bv; end
        else     begin a8  = ~av[7:0]; b8 = ~bv[7:0]; end
        check({tag, "_busy_run"}, w32 ? busy32 : busy8, 1'b1);
        c = 0;
        while (c < 20) begin
            @(posedge clk); #1;
            c++;
            if (w32 ? done32 : done8) break;
        end
        check({tag, "_latency"}, c, lat);
        check({tag, "_result"}, w32 ? {gt32, eq32, lt32} : {gt8, eq8, lt8}, gel);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, w32 ? {done32, busy32} : {done8, busy8}, 2'b00);
        check({tag, "_hold"}, w32 ? {gt32, eq32, lt32} : {gt8, eq8, lt8}, gel);
    endtask

    initial begin : main
        int dones;
        rst8_n  = 1'b0;
        rst32_n = 1'b0;
        start8  = 1'b0;
        start32 = 1'b0;
        a8 = '0; b8 = '0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset8_outs",  {busy8, done8, gt8, eq8, lt8}, 5'b0);
        check("reset32_outs", {busy32, done32, gt32, eq32, lt32}, 5'b0);
        @(negedge clk);
        rst8_n  = 1'b1;
        rst32_n = 1'b1;

        run_cmp(1'b0, 32'h24, 32'h42, 2, 3'b001, "w8_24_42");
        run_cmp(1'b0, 32'h53, 32'h35, 2, 3'b100, "w8_53_35");
        run_cmp(1'b0, 32'h35, 32'h53, 2, 3'b001, "w8_35_53");
        run_cmp(1'b0, 32'h33, 32'h33, 2, 3'b010, "w8_33_33");
        run_cmp(1'b0, 32'h31, 32'h32, 2, 3'b001, "w8_31_32");
        run_cmp(1'b0, 32'hF0, 32'hEF, 2, 3'b100, "w8_F0_EF");

        // start held 6 cycles; operands change right after the first acceptance
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
        @(posedge clk); #1;
        a8 = 8'h90;
        dones = 0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            if (done8) dones++;
            if (e == 2) check("hold_first_result", {gt8, eq8, lt8}, 3'b001);
            if (e == 3) check("hold_idle_busy", busy8, 1'b0);
            if (e == 4) check("hold_reaccept_busy", busy8, 1'b1);
        end
        start8 = 1'b0;
        check("hold_single_done", dones, 1);
        @(posedge clk); #1;
        check("hold_second_done", done8, 1'b1);
        check("hold_second_result", {gt8, eq8, lt8}, 3'b100);
        @(posedge clk); #1;
        check("hold_end_idle", {done8, busy8}, 2'b00);

        // asynchronous abort one cycle after acceptance
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", busy8, 1'b1);
        rst8_n = 1'b0;
        #1;
        check("abort_outs_async", {busy8, done8, gt8, eq8, lt8}, 5'b0);
        dones = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        check("abort_no_done", dones, 0);
        @(negedge clk);
        rst8_n = 1'b1;
        run_cmp(1'b0, 32'h24, 32'h42, 2, 3'b001, "w8_post_rst");

        run_cmp(1'b1, 32'hFFFFFFFF, 32'h00000000, 8, 3'b100, "w32_ff_00");
        run_cmp(1'b1, 32'h80000000, 32'h7FFFFFFF, 8, 3'b100, "w32_msb");
        run_cmp(1'b1, 32'h12345678, 32'h12345679, 8, 3'b001, "w32_lsb_lt");
        run_cmp(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 8, 3'b010, "w32_eq");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_seq_comparator
